// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - op encodings, FSM states and default latencies for the multiply/divide unit
package md_unit_pkg;

    // md_op encodings driven by the decoder for md-class instructions
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    md_state_e   state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] p_hi, p_hi_n;
    logic [31:0] p_lo, p_lo_n;
    logic        p_wr, p_wr_n;
    logic [31:0] hi_n, lo_n;
    md_op_e      op;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] q_s, r_s, q_u, r_u;
    logic        b_zero;

    assign op   = md_op_e'(md_op);
    assign busy = (state == ST_RUN);

    // Full results computed from the operands; only captured when a mult/div starts
    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};
        b_zero = (B == 32'd0);
        a_mag  = mag32(A);
        b_mag  = mag32(B);
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        q_u    = 32'd0;
        r_u    = 32'd0;
        if (!b_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = A / B;
            r_u   = A % B;
        end
        // quotient truncates toward zero, remainder follows the dividend's sign
        q_s = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s = A[31] ? (~r_mag + 32'd1) : r_mag;
    end

    // Next-state logic: launch in IDLE, count down in RUN, commit on the last edge
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p_hi_n  = p_hi;
        p_lo_n  = p_lo;
        p_wr_n  = p_wr;
        hi_n    = HI;
        lo_n    = LO;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT: begin
                            p_hi_n  = prod_s[63:32];
                            p_lo_n  = prod_s[31:0];
                            p_wr_n  = 1'b1;
                            cnt_n   = MULT_N;
                            state_n = ST_RUN;
                        end
                        MD_MULTU: begin
                            p_hi_n  = prod_u[63:32];
                            p_lo_n  = prod_u[31:0];
                            p_wr_n  = 1'b1;
                            cnt_n   = MULT_N;
                            state_n = ST_RUN;
                        end
                        MD_DIV: begin
                            p_hi_n  = r_s;
                            p_lo_n  = q_s;
                            p_wr_n  = !b_zero;
                            cnt_n   = DIV_N;
                            state_n = ST_RUN;
                        end
                        MD_DIVU: begin
                            p_hi_n  = r_u;
                            p_lo_n  = q_u;
                            p_wr_n  = !b_zero;
                            cnt_n   = DIV_N;
                            state_n = ST_RUN;
                        end
                        MD_MTHI: hi_n = A;
                        MD_MTLO: lo_n = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = ST_IDLE;
                    p_wr_n  = 1'b0;
                    // a zero divisor leaves HI/LO untouched
                    if (p_wr) begin
                        hi_n = p_hi;
                        lo_n = p_lo;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and architectural registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            p_wr  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            p_hi  <= p_hi_n;
            p_lo  <= p_lo_n;
            p_wr  <= p_wr_n;
            HI    <= hi_n;
            LO    <= lo_n;
        end
    end

    // The stall unit must never present a new md op while one is running
    start_while_busy: assert property (@(posedge clk) disable iff (!reset_n) !(start && busy))
        else $warning("md_unit: start while busy, request ignored");

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit against a longint reference model
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int failures;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    md_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural effect of one completed operation
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT: begin
                sp = sa * sb;
                exp_hi = sp[63:32];
                exp_lo = sp[31:0];
            end
            MD_MULTU: begin
                up = ua * ub;
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            MD_DIV: if (b != 32'd0) begin
                sq = sa / sb;
                sr = sa % sb;
                exp_hi = sr[31:0];
                exp_lo = sq[31:0];
            end
            MD_DIVU: if (b != 32'd0) begin
                exp_hi = 32'(ua % ub);
                exp_lo = 32'(ua / ub);
            end
            MD_MTHI: exp_hi = a;
            MD_MTLO: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue a mult/div; optionally inject an mtlo while busy at cycle 'inject'
    task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inject);
        int n;
        logic [31:0] old_hi, old_lo;
        n = (op == MD_MULT || op == MD_MULTU) ? NM : ND;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(op, a, b);
        start = 1'b1;
        md_op = op;
        A = a;
        B = b;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == inject) begin
                start = 1'b1;
                md_op = MD_MTLO;
                A = 32'h55;
            end else begin
                start = 1'b0;
                md_op = 3'($urandom_range(0, 6));
                A = $urandom;
                B = $urandom;
            end
            checks++;
            if (busy !== 1'b1 || HI !== old_hi || LO !== old_lo) begin
                failures++;
                $display("FAIL %s busy cycle %0d: busy=%b HI=%h LO=%h required busy=1 HI=%h LO=%h",
                         name, i, busy, HI, LO, old_hi, old_lo);
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            failures++;
            $display("FAIL %s result: busy=%b HI=%h LO=%h required busy=0 HI=%h LO=%h",
                     name, busy, HI, LO, exp_hi, exp_lo);
        end
    endtask

    // Issue a single-cycle op (mthi/mtlo/none)
    task automatic run_single(input string name, input logic [2:0] op, input logic [31:0] a);
        model(op, a, 32'd0);
        start = 1'b1;
        md_op = op;
        A = a;
        B = $urandom;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            failures++;
            $display("FAIL %s: busy=%b HI=%h LO=%h required busy=0 HI=%h LO=%h",
                     name, busy, HI, LO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        md_op = MD_NONE;
        A = 32'd0;
        B = 32'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL reset: busy=%b HI=%h LO=%h required 0/0/0", busy, HI, LO);
        end
    endtask

    task automatic test_directed();
        run_md("mult_m1x2", MD_MULT, 32'hFFFF_FFFF, 32'd2, -1);
        run_md("multu_m1x2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, -1);
        run_md("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        run_md("divu_7_2", MD_DIVU, 32'd7, 32'd2, -1);
        run_single("mthi", MD_MTHI, 32'h11);
        run_single("mtlo", MD_MTLO, 32'h22);
        run_single("none", MD_NONE, 32'h99);
        run_md("div_by_zero", MD_DIV, 32'd1234, 32'd0, -1);
        run_md("divu_by_zero", MD_DIVU, 32'd1234, 32'd0, -1);
        run_md("div_overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_md("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, -1);
    endtask

    task automatic test_reset_abort();
        start = 1'b1;
        md_op = MD_DIV;
        A = 32'd100;
        B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b HI=%h LO=%h required 0/0/0", busy, HI, LO);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_md("mult_after_reset", MD_MULT, 32'd3, 32'd4, -1);
    endtask

    task automatic test_ignore_while_busy();
        run_md("mult_with_mtlo", MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        run_md("mult_back_to_back", MD_MULT, 32'd7, 32'hFFFF_FFFD, -1);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 6));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU)
                run_md("random_md", op, a, b, -1);
            else
                run_single("random_single", op, a);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_reset_abort();
        test_ignore_while_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit in the E stage of the five-stage pipeline. It owns the HI/LO registers, executes mult/multu/div/divu over a fixed number of cycles, and executes mthi/mtlo in one cycle. It produces the `busy` indication consumed by the stall unit: a D-stage md-class instruction stalls while `start | busy` is high.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration in cycles for mult/multu; legal range 1–15.
- `DIV_CYCLES`, default 10: busy duration in cycles for div/divu; legal range 1–15.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: E-stage instruction is md-class and valid this cycle.
- `md_op` input 3: operation code `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`, `MD_NONE`.
- `A` input 32: rs operand, already forwarded.
- `B` input 32: rt operand, already forwarded.
- `busy` output 1: a mult/div is in progress.
- `HI` output 32: architectural HI, registered.
- `LO` output 32: architectural LO, registered.

## Operation
- Reset, asynchronous on `reset_n` low, takes effect immediately:
  - `busy`=0, `HI`=0, `LO`=0, counter=0, pending results=0.
  - An operation in flight is aborted and its result is discarded.
- States:
  - IDLE (`busy`=0).
  - RUN (`busy`=1, 4-bit counter `cnt`).
- IDLE, `start`=1 with a mult/div op:
  - Compute the 64-bit result from `A`/`B` and hold it in pending registers `p_hi`/`p_lo`.
  - `cnt` ← `MULT_CYCLES` or `DIV_CYCLES`; go to RUN.
- RUN: `cnt` decrements each edge. On the edge where `cnt`==1: `HI`←`p_hi`, `LO`←`p_lo`, go to IDLE.
- mthi/mtlo, `start`=1 in IDLE: `HI`←`A` or `LO`←`A` on that edge. `busy` stays 0.
- `start`=1 while in RUN: ignored, including mthi/mtlo. The stall unit makes this unreachable; an SVA assertion flags it.
- `MD_NONE` with `start`=1: no effect.
- Arithmetic:
  - mult: signed 32×32 → 64. multu: unsigned 32×32 → 64. HI gets the upper word, LO the lower.
  - div/divu: LO=quotient, HI=remainder. Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero (`B`==0): HI/LO keep their old values at completion, but `busy` is still asserted for the full `DIV_CYCLES`.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `HI`/`LO` outputs always show the committed values, never pending ones. mfhi/mflo in D stall on `start|busy`, so they always read the final values.

## Timing
- `start` sampled at edge k (mult/div): `busy` is high from after edge k through edge k+N−1. At edge k+N, `HI`/`LO` update and `busy` falls in the same cycle. N=`MULT_CYCLES` or `DIV_CYCLES`.
- Back-to-back: a new `start` is legal in the first cycle `busy` is 0, i.e. sampled at edge k+N+1. No bubble is required beyond that.
- mthi/mtlo: result visible after the same edge that samples `start`.
- `busy` is driven directly by the state register; it has no combinational path from the inputs.

## Structure
- `const.v` gains the `MD_*` op encodings (3 bits) and the default cycle counts.
- No sub-module. The multiply and divide are inline behavioural `*`, `/`, `%` on sign-adjusted operands. The pipeline-stage CU gains an `md` class output and `md_op` decoding.

## Test plan
- Reset, then mult A=0xFFFFFFFF (−1), B=2 at edge 0 → `busy` high for edges 1–4; after edge 5: HI=0xFFFFFFFF, LO=0xFFFFFFFE, `busy`=0.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div A=−7 (0xFFFFFFF9), B=2 → after 10 cycles: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu 7/2 → LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo (each visible next cycle, `busy` never high). Then div by 0 → `busy` high 10 cycles; HI=0x11, LO=0x22 unchanged.
- Start div, pulse `reset_n` low in cycle 4 → `busy`, HI, LO drop to 0 immediately. After release, a mult 3×4 completes normally with LO=12.
- Start mult, then assert `start` with mtlo A=0x55 in cycle 2 → ignored. Assertion fires; LO equals the mult result after completion. mult issued at edge k+6 is accepted.
